// File: rtl/sc_ulpi_pkg.sv
// Shared ULPI link-side types: TX CMD codes, RX CMD layout and the register-access sequencer states.
package sc_ulpi_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned TMO_W   = 8;

    typedef enum logic [1:0] {
        CCD_SPECIAL   = 2'b00,
        CCD_TRANSMIT  = 2'b01,
        CCD_REG_WRITE = 2'b10,
        CCD_REG_READ  = 2'b11
    } ulpiCCD_e;

    // Immediate-address payload value that announces a following extended-address byte.
    localparam logic [5:0] cpdExtend = 6'h2F;

    typedef struct packed {
        logic       alt_int;
        logic       id_gnd;
        logic [1:0] rx_event;
        logic [1:0] vbus_state;
        logic [1:0] line_state;
    } rxCmd_s;

    typedef enum logic [3:0] {
        IDLE,
        TXCMD,
        EXTADR,
        WDATA,
        STP,
        RTURN,
        RDATA,
        RWAIT,
        ABORT,
        DONE
    } ulpiRegCtlState_e;

    function automatic logic [BYTE_W-1:0] ulpi_txcmd(input ulpiCCD_e ccd, input logic [5:0] cpd);
        return {ccd, cpd};
    endfunction

endpackage

// File: rtl/sc_ulpi_regctl.sv
// ULPI register read/write sequencer with PHY-abort retry and NXT timeout.
// Optional RX CMD capture outputs are enabled by defining SC_ULPI_REGCTL_RXCMD_EN.
module sc_ulpi_regctl
    import sc_ulpi_pkg::*;
#(
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned NXT_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req,
    input  logic              i_req_wr,
    input  logic              i_req_ext,
    input  logic [BYTE_W-1:0] i_req_addr,
    input  logic [BYTE_W-1:0] i_req_wdata,
    output logic              o_ack,
    output logic [BYTE_W-1:0] o_rdata,
    output logic              o_err,
    output logic              o_busy,
    input  logic              i_ulpi_dir,
    input  logic              i_ulpi_nxt,
    input  logic [BYTE_W-1:0] i_ulpi_data,
    output logic [BYTE_W-1:0] o_ulpi_data,
    output logic              o_ulpi_data_oe,
    output logic              o_ulpi_stp
`ifdef SC_ULPI_REGCTL_RXCMD_EN
    ,
    output rxCmd_s            o_rxcmd,
    output logic              o_rxcmd_vld
`endif
);

    ulpiRegCtlState_e    r_state;
    ulpiRegCtlState_e    w_next;
    logic                r_wr;
    logic                r_ext;
    logic [BYTE_W-1:0]   r_addr;
    logic [BYTE_W-1:0]   r_wdata;
    logic [RETRY_W-1:0]  r_retry;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_err_flag;
    logic [BYTE_W-1:0]   r_rcap;
    logic                r_ack;
    logic [BYTE_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_busy;
    logic [BYTE_W-1:0]   r_data_o;
    logic                r_drive;
    logic                r_stp;

    logic                w_accept;
    logic                w_err_set;
    logic                w_retry_inc;
    logic                w_rcap;
    logic                w_stall;
    logic                w_tmo_hit;
    logic                w_byte_phase;
    ulpiRegCtlState_e    w_after_cmd;
    logic                w_cmd_wr;
    logic                w_cmd_ext;
    logic [BYTE_W-1:0]   w_cmd_addr;
    ulpiCCD_e            w_ccd;
    logic [BYTE_W-1:0]   w_byte;

    // Next-state and per-transition controls.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_err_set   = 1'b0;
        w_retry_inc = 1'b0;
        w_rcap      = 1'b0;
        w_stall     = ~i_ulpi_dir & ~i_ulpi_nxt;
        w_tmo_hit   = (r_tmo == TMO_W'(NXT_TIMEOUT - 1));
        w_after_cmd = r_wr ? WDATA : RTURN;
        w_byte_phase = (r_state == TXCMD) || (r_state == EXTADR) || (r_state == WDATA);

        case (r_state)
            IDLE: begin
                if (i_req && !i_ulpi_dir) begin
                    w_accept = 1'b1;
                    w_next   = TXCMD;
                end
            end
            TXCMD, EXTADR, WDATA: begin
                if (i_ulpi_dir) begin
                    w_next = ABORT;
                end else if (i_ulpi_nxt) begin
                    if (r_state == TXCMD && r_ext) begin
                        w_next = EXTADR;
                    end else if (r_state == WDATA) begin
                        w_next = STP;
                    end else begin
                        w_next = w_after_cmd;
                    end
                end else if (w_tmo_hit) begin
                    w_err_set = 1'b1;
                    w_next    = STP;
                end
            end
            STP: begin
                w_next = DONE;
            end
            RTURN: begin
                w_next = (i_ulpi_dir && !i_ulpi_nxt) ? RDATA : ABORT;
            end
            RDATA: begin
                w_rcap = 1'b1;
                w_next = RWAIT;
            end
            RWAIT: begin
                if (!i_ulpi_dir) begin
                    w_next = DONE;
                end
            end
            ABORT: begin
                if (!i_ulpi_dir) begin
                    if (r_retry == RETRY_W'(MAX_RETRY)) begin
                        w_err_set = 1'b1;
                        w_next    = DONE;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_next      = TXCMD;
                    end
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Bus byte for the upcoming state; the request is not latched yet when leaving IDLE.
    always_comb begin
        w_cmd_wr   = (r_state == IDLE) ? i_req_wr   : r_wr;
        w_cmd_ext  = (r_state == IDLE) ? i_req_ext  : r_ext;
        w_cmd_addr = (r_state == IDLE) ? i_req_addr : r_addr;
        w_ccd      = CCD_REG_READ;
        if (w_cmd_wr) begin
            w_ccd = CCD_REG_WRITE;
        end
        w_byte = '0;
        case (w_next)
            TXCMD:   w_byte = ulpi_txcmd(w_ccd, w_cmd_ext ? cpdExtend : w_cmd_addr[5:0]);
            EXTADR:  w_byte = r_addr;
            WDATA:   w_byte = r_wdata;
            default: w_byte = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state    <= IDLE;
            r_wr       <= 1'b0;
            r_ext      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_retry    <= '0;
            r_tmo      <= '0;
            r_err_flag <= 1'b0;
            r_rcap     <= '0;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_data_o   <= '0;
            r_drive    <= 1'b0;
            r_stp      <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_wr    <= i_req_wr;
                r_ext   <= i_req_ext;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
            end

            if (w_next == DONE || w_next == IDLE) begin
                r_retry <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + RETRY_W'(1);
            end

            if (w_next != r_state) begin
                r_tmo <= '0;
            end else if (w_stall && w_byte_phase) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            if (w_accept) begin
                r_err_flag <= 1'b0;
            end else if (w_err_set) begin
                r_err_flag <= 1'b1;
            end

            if (w_rcap) begin
                r_rcap <= i_ulpi_data;
            end

            // Read data only moves on a successful read completion.
            if (w_next == DONE && !r_wr && !(r_err_flag || w_err_set)) begin
                r_rdata <= r_rcap;
            end

            r_ack    <= (w_next == DONE);
            r_err    <= (w_next == DONE) && (r_err_flag || w_err_set);
            r_busy   <= (w_next != IDLE) && (w_next != DONE);
            r_stp    <= (w_next == STP);
            r_drive  <= (w_next == TXCMD) || (w_next == EXTADR) || (w_next == WDATA) || (w_next == STP);
            r_data_o <= w_byte;
        end
    end

    assign o_ack          = r_ack;
    assign o_rdata        = r_rdata;
    assign o_err          = r_err;
    assign o_busy         = r_busy;
    assign o_ulpi_data    = r_data_o;
    assign o_ulpi_stp     = r_stp;
    assign o_ulpi_data_oe = r_drive & ~i_ulpi_dir;

`ifdef SC_ULPI_REGCTL_RXCMD_EN
    rxCmd_s r_rxcmd;
    logic   r_rxcmd_vld;
    logic   w_rx_hit;

    // PHY-owned bus bytes outside the read turnaround/data slots are RX CMDs.
    assign w_rx_hit = i_ulpi_dir & ~i_ulpi_nxt & (r_state != RTURN) & (r_state != RDATA);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rxcmd     <= '0;
            r_rxcmd_vld <= 1'b0;
        end else begin
            r_rxcmd_vld <= w_rx_hit;
            if (w_rx_hit) begin
                r_rxcmd <= rxCmd_s'(i_ulpi_data);
            end
        end
    end

    assign o_rxcmd     = r_rxcmd;
    assign o_rxcmd_vld = r_rxcmd_vld;
`endif

endmodule

// File: tb/tb_sc_ulpi_regctl.sv
// Bench for sc_ulpi_regctl: reactive PHY model, directed vector table, random transactions, corner sequences.
module tb_sc_ulpi_regctl;

    localparam int MAX_RETRY   = 3;
    localparam int NXT_TIMEOUT = 255;

    logic       clk;
    logic       rstn;
    logic       req;
    logic       req_wr;
    logic       req_ext;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       ack;
    logic [7:0] rdata;
    logic       err;
    logic       busy;
    logic       dir;
    logic       nxt;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe;
    logic       stp;
`ifdef SC_ULPI_REGCTL_RXCMD_EN
    logic [7:0] rxcmd;
    logic       rxcmd_vld;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] m_rdata = 8'h00;

    sc_ulpi_regctl #(.MAX_RETRY(MAX_RETRY), .NXT_TIMEOUT(NXT_TIMEOUT)) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_req          (req),
        .i_req_wr       (req_wr),
        .i_req_ext      (req_ext),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_ack          (ack),
        .o_rdata        (rdata),
        .o_err          (err),
        .o_busy         (busy),
        .i_ulpi_dir     (dir),
        .i_ulpi_nxt     (nxt),
        .i_ulpi_data    (din),
        .o_ulpi_data    (dout),
        .o_ulpi_data_oe (oe),
        .o_ulpi_stp     (stp)
`ifdef SC_ULPI_REGCTL_RXCMD_EN
        ,
        .o_rxcmd        (rxcmd),
        .o_rxcmd_vld    (rxcmd_vld)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       ext;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdv;
        int         n_abort;
        int         abort_at;
        int         stall;
        logic [7:0] exp_cmd;
        int         exp_lat;
        bit         drop_early;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycles from request cycle to ACK cycle inclusive, from PHY timing and the abort/retry rules.
    function automatic int model_lat(input bit wr, input int nbytes, input int n_ab, input int at,
                                     input int stall);
        int per_ab;
        per_ab = at * (stall + 1) + 5;
        if (n_ab > MAX_RETRY) return 1 + (MAX_RETRY + 1) * per_ab + 1;
        return 1 + n_ab * per_ab + nbytes * (stall + 1) + (wr ? 1 : 3) + 1;
    endfunction

    task automatic run_txn(input vec_t v);
        logic [7:0] exp_b[$];
        logic [7:0] got_b[$];
        int  cyc, aborts, hold, st_left, rd_ph, stp_cnt;
        bit  done, abort_pend, exp_err;
        exp_b.delete();
        got_b.delete();
        exp_b.push_back(v.exp_cmd);
        if (v.ext) exp_b.push_back(v.addr);
        if (v.wr) exp_b.push_back(v.wdata);
        exp_err = (v.n_abort > MAX_RETRY);
        cyc = 0; aborts = 0; hold = 0; st_left = v.stall; rd_ph = 0; stp_cnt = 0;
        done = 0; abort_pend = 0;
        @(posedge clk); #1;
        req = 1'b1; req_wr = v.wr; req_ext = v.ext; req_addr = v.addr; req_wdata = v.wdata;
        dir = 1'b0; nxt = 1'b0; din = 8'h00;
        while (!done && cyc < 1000) begin
            @(posedge clk); cyc++; #1;
            if (v.drop_early && cyc == 2) req = 1'b0;
            nxt = 1'b0;
            din = 8'h00;
            if (abort_pend) begin
                abort_pend = 0; aborts++; hold = 3; got_b.delete();
            end
            if (hold > 0) begin
                dir = 1'b1; hold--;
            end else if (rd_ph == 1) begin
                dir = 1'b1; rd_ph = 2;
            end else if (rd_ph == 2) begin
                dir = 1'b1; din = v.rdv; rd_ph = 0;
            end else begin
                dir = 1'b0;
            end
            #1;
            if (dir) begin
                chk("oe_while_dir", 32'(oe), 32'd0);
            end else if (oe && !stp) begin
                if (aborts < v.n_abort && got_b.size() == v.abort_at) begin
                    abort_pend = 1;
                end else if (st_left > 0) begin
                    st_left--;
                end else begin
                    nxt = 1'b1;
                    got_b.push_back(dout);
                    st_left = v.stall;
                    if (!v.wr && got_b.size() == exp_b.size()) rd_ph = 1;
                end
            end
            if (stp) begin
                stp_cnt++;
                chk("stp_bus_byte", 32'({oe, dout}), 32'h100);
            end
            @(negedge clk);
            if (cyc == 1) chk("busy_after_accept", 32'(busy), 32'd1);
            if (ack) done = 1;
        end
        if (!done) begin
            chk("ack_timeout", 32'(ack), 32'd1);
        end else begin
            chk("err", 32'(err), 32'(exp_err));
            chk("busy_at_ack", 32'(busy), 32'd0);
            chk("latency", 32'(cyc + 1), 32'(v.exp_lat));
            chk("n_bytes", 32'(got_b.size()), exp_err ? 32'd0 : 32'(exp_b.size()));
            if (!exp_err) begin
                foreach (exp_b[i]) begin
                    if (i < got_b.size()) chk("bus_byte", 32'(got_b[i]), 32'(exp_b[i]));
                end
            end
            chk("stp_pulses", 32'(stp_cnt), (v.wr && !exp_err) ? 32'd1 : 32'd0);
            if (!v.wr && !exp_err) m_rdata = v.rdv;
            chk("rdata", 32'(rdata), 32'(m_rdata));
        end
        req = 1'b0;
        nxt = 1'b0;
        @(negedge clk);
        chk("ack_single", 32'(ack), 32'd0);
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        int cyc, stp_n, stp_cyc, nb, sel;
        bit got_ack;

        tbl[0] = '{1'b1, 1'b0, 8'h04, 8'h45, 8'h00, 0, 0, 0, 8'h84,  5, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h0A, 8'h00, 8'h06, 0, 0, 0, 8'hCA,  6, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'h85, 8'h5A, 8'h00, 0, 0, 0, 8'hAF,  6, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h91, 8'h00, 8'hC3, 0, 0, 0, 8'hEF,  7, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h04, 8'h45, 8'h00, 1, 0, 0, 8'h84, 10, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 8'h04, 8'h45, 8'h00, 4, 0, 0, 8'h84, 22, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 8'h3F, 8'hFF, 8'h00, 0, 0, 2, 8'hBF,  9, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 8'h40, 8'h00, 8'h7E, 1, 1, 0, 8'hEF, 13, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'h15, 8'h00, 8'hA5, 0, 0, 1, 8'hD5,  7, 1'b0};

        rstn = 1'b0; req = 1'b0; req_wr = 1'b0; req_ext = 1'b0; req_addr = 8'h00;
        req_wdata = 8'h00; dir = 1'b0; nxt = 1'b0; din = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_stp", 32'(stp), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        // Request held while PHY owns the bus must wait.
        @(posedge clk); #1;
        req = 1'b1; req_wr = 1'b0; req_ext = 1'b0; req_addr = 8'h0A; dir = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("dir_idle_busy", 32'(busy), 32'd0);
            chk("dir_idle_oe", 32'(oe), 32'd0);
        end
        run_txn('{1'b0, 1'b0, 8'h0A, 8'h00, 8'h39, 0, 0, 0, 8'hCA, 6, 1'b0});

        // NXT never arrives: timeout forces STP then an errored ACK.
        @(posedge clk); #1;
        req = 1'b1; req_wr = 1'b1; req_ext = 1'b0; req_addr = 8'h04; req_wdata = 8'h45;
        dir = 1'b0; nxt = 1'b0;
        cyc = 0; stp_n = 0; stp_cyc = -1; got_ack = 0;
        while (!got_ack && cyc < 600) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (stp) begin stp_n++; stp_cyc = cyc; end
            if (ack) got_ack = 1;
        end
        req = 1'b0;
        chk("tmo_ack_seen", 32'(got_ack), 32'd1);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_latency", 32'(cyc + 1), 32'(NXT_TIMEOUT + 3));
        chk("tmo_stp_pulses", 32'(stp_n), 32'd1);
        chk("tmo_stp_before_ack", 32'(stp_cyc + 1), 32'(cyc));
        chk("tmo_rdata_hold", 32'(rdata), 32'(m_rdata));
        @(negedge clk);

        // Reset during the write-data phase abandons the transfer.
        @(posedge clk); #1;
        req = 1'b1; req_wr = 1'b1; req_ext = 1'b0; req_addr = 8'h04; req_wdata = 8'h45;
        dir = 1'b0; nxt = 1'b0;
        @(posedge clk); #1; nxt = 1'b1;
        @(posedge clk); #1; nxt = 1'b0; rstn = 1'b0;
        @(negedge clk);
        chk("rst_mid_wdata_oe", 32'(oe), 32'd1);
        chk("rst_mid_wdata_byte", 32'(dout), 32'h45);
        @(posedge clk); #1;
        rstn = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("rst_mid_oe", 32'(oe), 32'd0);
        chk("rst_mid_stp", 32'(stp), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        got_ack = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) got_ack = 1;
        end
        chk("rst_mid_no_ack", 32'(got_ack), 32'd0);
        m_rdata = 8'h00;
        chk("rst_mid_rdata", 32'(rdata), 32'(m_rdata));
        run_txn('{1'b1, 1'b0, 8'h04, 8'h45, 8'h00, 0, 0, 0, 8'h84, 5, 1'b0});

        // Random transactions against the transaction-level PHY/latency model.
        for (int t = 0; t < 40; t++) begin
            rv.wr    = 1'($urandom_range(0, 1));
            rv.ext   = 1'($urandom_range(0, 1));
            rv.addr  = 8'($urandom_range(0, 255));
            rv.wdata = 8'($urandom_range(0, 255));
            rv.rdv   = 8'($urandom_range(0, 255));
            rv.stall = $urandom_range(0, 3);
            nb = 1 + (rv.ext ? 1 : 0) + (rv.wr ? 1 : 0);
            sel = $urandom_range(0, 9);
            rv.n_abort = (sel < 6) ? 0 : (sel < 8) ? 1 : (sel < 9) ? 2 : MAX_RETRY + 1;
            rv.abort_at = $urandom_range(0, nb - 1);
            rv.exp_cmd = {(rv.wr ? 2'b10 : 2'b11), (rv.ext ? 6'h2F : rv.addr[5:0])};
            rv.exp_lat = model_lat(rv.wr, nb, rv.n_abort, rv.abort_at, rv.stall);
            rv.drop_early = 1'($urandom_range(0, 1));
            run_txn(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
